// File: rtl/audio_dac_fifo.sv
// audio_dac_fifo: playback sample buffer ahead of the codec transceiver.
// Accepts packed {left, right} samples over valid/ready, stores them in a
// circular RAM, and returns one sample per dacdat_req on a registered output.
// A request on an empty FIFO is an underrun: it pulses underrun, bumps a
// saturating counter and substitutes a sample so the serial stream never stalls.
//
// Build option:
//   AUDIO_DAC_FIFO_HOLD_EN defined   -> underrun repeats the last sample
//   AUDIO_DAC_FIFO_HOLD_EN undefined -> underrun outputs silence (all zeros)

module audio_dac_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int LOW_WM = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       dacdat_req,
  output logic [WIDTH-1:0]           dacdat_in,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       low_wm,
  output logic                       underrun,
  output logic [15:0]                underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_LOW  = LW'(LOW_WM);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic level_zero;
  logic do_pop;
  logic do_urun;
  logic do_push;

  assign level_zero = (level == '0);
  assign s_ready    = (level != LEVEL_FULL);
  assign low_wm     = (level < LEVEL_LOW);

  // A clear swallows every push and request in its cycle.
  assign do_pop  = dacdat_req & ~level_zero & ~clear;
  assign do_urun = dacdat_req &  level_zero & ~clear;
  // At full, a same-cycle pop frees the slot being written, so the sample is
  // still taken; the read of that slot returns the old contents.
  assign do_push = s_valid & (s_ready | do_pop) & ~clear;

  // Sample storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Write pointer advances per accepted sample and wraps at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Read pointer advances per served request and wraps at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: an underrun removes nothing, so push+underrun still counts up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (clear) begin
      level <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Output sample register: next entry on a pop, substitute on an underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dacdat_in <= '0;
    end else if (clear) begin
      dacdat_in <= '0;
    end else if (do_pop) begin
      dacdat_in <= mem[rd_ptr];
    end else if (do_urun) begin
`ifdef AUDIO_DAC_FIFO_HOLD_EN
      dacdat_in <= dacdat_in;
`else
      dacdat_in <= '0;
`endif
    end
  end

  // One-cycle underrun flag following the failed request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= do_urun;
    end
  end

  // Underrun counter, sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (clear) begin
      underrun_cnt <= '0;
    end else if (do_urun && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule
